// File: rtl/gcm_frame_splitter_if.sv
// Framed-input and AAD/payload output streams of the GCM frame splitter.
// The splitter connects through the slave modport; its environment uses master.
interface gcm_frame_splitter_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              aad_valid;
  logic              aad_ready;
  logic              aad_last;
  logic [DATA_W-1:0] aad_data;
  logic [KEEP_W-1:0] aad_keep;

  logic              din_valid;
  logic              din_ready;
  logic              din_last;
  logic [DATA_W-1:0] din_data;
  logic [KEEP_W-1:0] din_keep;

  modport slave (
    input  in_valid, in_data, in_last, aad_ready, din_ready,
    output in_ready, aad_valid, aad_last, aad_data, aad_keep,
           din_valid, din_last, din_data, din_keep
  );

  modport master (
    output in_valid, in_data, in_last, aad_ready, din_ready,
    input  in_ready, aad_valid, aad_last, aad_data, aad_keep,
           din_valid, din_last, din_data, din_keep
  );
endinterface

// File: rtl/gcm_frame_splitter.sv
// Splits an AAD || payload || tag frame into the GCM core's AAD and payload
// streams, capturing the trailing tag for decrypt frames.
module gcm_frame_splitter #(
  parameter int unsigned CNT_W = 58
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [63:0]            len_aad_bits,
  input  logic [63:0]            len_pld_bits,
  input  logic                   tag_en,
  gcm_frame_splitter_if.slave    bus,
  output logic [127:0]           tag_in,
  output logic                   tag_in_we,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err
);

  localparam int unsigned KEEP_W = 16;
  localparam int unsigned RES_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AAD, ST_PLD, ST_TAG, ST_DRAIN, ST_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  na_q, np_q;
  logic [RES_W-1:0]  res_aad_q, res_pld_q;
  logic              tag_en_q;
  logic              err_set;
  logic              tag_cap;

  logic [CNT_W-1:0]  na_start, np_start;
  logic              aad_final, pld_final, frame_final;
  logic              accept;

  // Byte enables of a stream's final word; a zero residue means a full word.
  function automatic logic [KEEP_W-1:0] last_keep(input logic [RES_W-1:0] r);
    if (r == '0) last_keep = '1;
    else         last_keep = KEEP_W'(16'hFFFF << (5'd16 - {1'b0, r}));
  endfunction

  // Word counts are ceil(len/128); the OR folds in any partial word.
  assign na_start = CNT_W'(len_aad_bits[63:7]) + CNT_W'(|len_aad_bits[6:0]);
  assign np_start = CNT_W'(len_pld_bits[63:7]) + CNT_W'(|len_pld_bits[6:0]);

  assign aad_final = (cnt_q == na_q - CNT_W'(1));
  assign pld_final = (cnt_q == np_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_set        = 1'b0;
    tag_cap        = 1'b0;
    accept         = 1'b0;
    frame_final    = 1'b0;
    bus.in_ready   = 1'b0;
    bus.aad_valid  = 1'b0;
    bus.aad_last   = 1'b0;
    bus.aad_data   = bus.in_data;
    bus.aad_keep   = '1;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.din_data   = bus.in_data;
    bus.din_keep   = '1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (na_start != '0)      state_d = ST_AAD;
          else if (np_start != '0) state_d = ST_PLD;
          else if (tag_en)         state_d = ST_TAG;
          else                     state_d = ST_FIN;
        end
      end

      ST_AAD: begin
        bus.in_ready  = bus.aad_ready;
        bus.aad_valid = bus.in_valid;
        bus.aad_last  = aad_final | bus.in_last;
        if (aad_final) bus.aad_keep = last_keep(res_aad_q);
        accept      = bus.in_valid & bus.aad_ready;
        frame_final = aad_final & (np_q == '0) & ~tag_en_q;
        if (accept) begin
          if (bus.in_last && !frame_final) begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = ST_FIN;
          end else if (aad_final) begin
            cnt_d = '0;
            if (frame_final && !bus.in_last) begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end else if (frame_final) state_d = ST_FIN;
            else if (np_q != '0)      state_d = ST_PLD;
            else                      state_d = ST_TAG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PLD: begin
        bus.in_ready  = bus.din_ready;
        bus.din_valid = bus.in_valid;
        bus.din_last  = pld_final | bus.in_last;
        if (pld_final) bus.din_keep = last_keep(res_pld_q);
        accept      = bus.in_valid & bus.din_ready;
        frame_final = pld_final & ~tag_en_q;
        if (accept) begin
          if (bus.in_last && !frame_final) begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = ST_FIN;
          end else if (pld_final) begin
            cnt_d = '0;
            if (frame_final && !bus.in_last) begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end else if (frame_final) state_d = ST_FIN;
            else                      state_d = ST_TAG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // The tag is always the frame's final word.
      ST_TAG: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          tag_cap = 1'b1;
          if (bus.in_last) state_d = ST_FIN;
          else begin
            err_set = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = ST_FIN;
      end

      ST_FIN:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Frame parameters, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      na_q      <= '0;
      np_q      <= '0;
      res_aad_q <= '0;
      res_pld_q <= '0;
      tag_en_q  <= 1'b0;
      tag_in    <= '0;
      tag_in_we <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tag_in_we <= tag_cap;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_FIN);
      if (tag_cap) tag_in <= bus.in_data;
      if (state_q == ST_IDLE && start) begin
        na_q      <= na_start;
        np_q      <= np_start;
        res_aad_q <= len_aad_bits[6:3];
        res_pld_q <= len_pld_bits[6:3];
        tag_en_q  <= tag_en;
        frame_err <= 1'b0;
      end else if (err_set) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/gcm_frame_splitter.md
Name: gcm_frame_splitter

Overview:
- Front-end feeder for the AES-GCM core: accepts one framed 128-bit input stream laid out as AAD || payload || optional tag, each region padded to a 16-byte boundary.
- Splits the frame into the core's AAD stream (aad_*) and payload stream (din_*), and for decrypt frames captures the trailing tag onto tag_in/tag_in_we.
- Acts as the transmitter for the core's AAD/payload receive interfaces, driven by the same bit lengths the core is programmed with.

Parameters:
- CNT_W, 58: width of the internal word counters; ceil(2^64 bits / 128) fits in 58 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches lengths and tag_en; ignored while busy=1
- len_aad_bits  in  64  AAD length in bits, multiple of 8
- len_pld_bits  in  64  payload length in bits, multiple of 8
- tag_en  in  1  frame carries a trailing tag word (decrypt)
- in_valid  in  1  framed input word valid
- in_ready  out  1  framed input word accepted
- in_data  in  128  framed input word; byte 0 in [127:120]
- in_last  in  1  final word of frame
- aad_valid  out  1  AAD word valid to core
- aad_ready  in  1  core accepts AAD word
- aad_last  out  1  final AAD word
- aad_data  out  128  AAD word
- aad_keep  out  16  byte enables; keep[15] is byte [127:120]
- din_valid  out  1  payload word valid to core
- din_ready  in  1  core accepts payload word
- din_last  out  1  final payload word
- din_data  out  128  payload word
- din_keep  out  16  byte enables, same mapping as aad_keep
- tag_in  out  128  captured tag, registered
- tag_in_we  out  1  one-cycle pulse when tag_in is updated
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- frame_err  out  1  sticky framing error; cleared by start

Behaviour:
- Reset: FSM=IDLE, counters 0. All outputs 0 except data/keep, which are don't-care while their valid is 0. Asynchronous reset mid-frame aborts immediately with no done pulse.
- Word counts:
  - na = ceil(len_aad_bits/128), np = ceil(len_pld_bits/128).
  - Last-word byte residue r = (len/8) mod 16.
  - Last-word keep = 16'hFFFF if r==0, else 16'hFFFF << (16-r). All other words have keep 16'hFFFF.
- FSM states: IDLE, AAD, PLD, TAG, DRAIN, FIN.
- IDLE + start: latch na, np, residues, tag_en; clear frame_err; busy=1. Next state is the first applicable of AAD (na>0), PLD (np>0), TAG (tag_en), else FIN.
- AAD: combinational pass-through with zero latency.
  - aad_valid = in_valid; in_ready = aad_ready; aad_data = in_data.
  - aad_last = 1 on word na-1.
  - After word na-1 is accepted, go to PLD, TAG, or FIN (first applicable). din_valid = 0 throughout.
- PLD: same pass-through on the din_* interface, with din_last = 1 on word np-1. Then go to TAG or FIN.
- TAG: in_ready = 1.
  - On accept: tag_in <= in_data, tag_in_we = 1 on the next cycle, go to FIN.
- FIN: one cycle. done = 1, busy <= 0, return to IDLE. done is therefore asserted the cycle after the final input handshake.
- Early in_last (in_last on an accepted word that is not the frame's final word):
  - The word is forwarded with the current stream's *_last forced to 1 and normal keep.
  - frame_err <= 1, no tag capture, go to FIN.
  - In TAG state, every accepted tag word is the final word, so early in_last cannot occur there.
- Missing in_last (final expected word accepted with in_last = 0):
  - That word is processed normally.
  - frame_err <= 1, then go to DRAIN instead of FIN.
- DRAIN: in_ready = 1; discard words until an accepted word has in_last = 1, then go to FIN.
- Zero-length frame (na = np = 0, tag_en = 0): FIN on the cycle after start, no input consumed, done pulses.
- Idle/unused stream: in_ready = 0 in IDLE and FIN. The inactive stream's valid is held at 0.
- Backpressure: no internal buffering, so in_ready follows the active ready combinationally. in_valid must not depend on in_ready.

Test Plan:
- AAD=160 bits, pld=256 bits, tag_en=0, continuous valid/ready -> 2 AAD words: keep FFFF, then F000 with aad_last; 2 din words keep FFFF with din_last on the 2nd; done the cycle after the last handshake; frame_err=0.
- AAD=0, pld=8 bits, tag_en=1, tag word 0x0123..CDEF -> no aad_valid; 1 din word keep 8000 with din_last; tag_in=0x0123..CDEF with tag_in_we pulsed once; done.
- AAD=128, pld=384 bits, din_ready toggled 1/0 each cycle -> no word lost or duplicated; in_ready mirrors din_ready; data order preserved.
- pld=3 words with in_last asserted on word 2 -> word 2 forwarded with din_last=1; frame_err=1; tag_in_we never pulses; done pulses.
- pld=1 word, source sends 3 words with in_last on the 3rd -> 1 din word forwarded; 2 words dropped in DRAIN; frame_err=1; done after the 3rd word; a following start clears frame_err.
- All lengths 0, tag_en=0 -> done the cycle after start. Separately, assert rst_n low mid-PLD -> outputs 0 and busy=0 immediately, no done pulse.
